// File: rtl/snake_px_responder.sv
// Avalon-MM pixel responder: decodes (x, y) pixel accesses to a linear frame-buffer index,
// queues writes in a small FIFO and services reads in order behind pending writes.
module snake_px_responder #(
    parameter int unsigned NUM_X      = 320,
    parameter int unsigned NUM_Y      = 240,
    parameter int unsigned X_LSB      = 1,
    parameter int unsigned Y_LSB      = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] px_address,
    input  logic        px_read,
    input  logic        px_write,
    input  logic [15:0] px_writedata,
    output logic [15:0] px_readdata,
    output logic        px_waitrequest,
    output logic [16:0] mem_address,
    output logic        mem_write,
    output logic        mem_read,
    output logic [15:0] mem_writedata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic [15:0] px_dropped
);

    localparam int unsigned IDX_W = 17;
    localparam int unsigned PIX_W = 16;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [PIX_W-1:0] data;
    } wr_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_DRAIN,
        RD_ISSUE,
        RD_WAIT,
        RD_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    wr_entry_t        r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] r_rd_idx;
    logic             r_rd_oor;
    logic [PIX_W-1:0] r_readdata;
    logic [15:0]      r_dropped;

    logic [8:0]       w_x;
    logic [7:0]       w_y;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    wr_entry_t        w_head;
    logic             w_latch_req;
    logic             w_load_en;
    logic [PIX_W-1:0] w_load_data;
    logic             w_mem_read;
    logic             w_unused;

    // Address decode; bits outside the x/y fields are don't-care.
    assign w_x        = px_address[X_LSB+8:X_LSB];
    assign w_y        = px_address[Y_LSB+7:Y_LSB];
    assign w_unused   = ^px_address;
    assign w_in_range = (32'(w_x) < NUM_X) && (32'(w_y) < NUM_Y);
    assign w_idx      = IDX_W'(w_y) * IDX_W'(NUM_X) + IDX_W'(w_x);

    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = px_write & ~w_full;
    assign w_push   = w_wr_acc & w_in_range;
    assign w_drop   = w_wr_acc & ~w_in_range;
    assign w_head   = r_fifo[r_rd_ptr];
    assign w_pop    = mem_write & mem_ready;

    // A read stalls until its own completion cycle; a concurrent write takes precedence.
    assign px_waitrequest = ~reset_n
                          | (px_write & w_full)
                          | (px_read & ~px_write & (r_state != RD_DONE));

    assign mem_write     = ~w_empty & (r_state != RD_ISSUE);
    assign mem_read      = w_mem_read;
    assign mem_address   = (r_state == RD_ISSUE) ? r_rd_idx : w_head.idx;
    assign mem_writedata = w_head.data;
    assign px_readdata   = r_readdata;
    assign px_dropped    = r_dropped;

    // Write FIFO storage and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo   <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= '{idx: w_idx, data: px_writedata};
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of absorbed out-of-range writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dropped <= '0;
        end else if (w_drop && (r_dropped != 16'hFFFF)) begin
            r_dropped <= r_dropped + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch_req = 1'b0;
        w_load_en   = 1'b0;
        w_load_data = '0;
        w_mem_read  = 1'b0;
        case (r_state)
            IDLE: begin
                if (px_read && !px_write) begin
                    w_latch_req = 1'b1;
                    w_state_nxt = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (w_empty) begin
                    if (r_rd_oor) begin
                        w_load_en   = 1'b1;
                        w_state_nxt = RD_DONE;
                    end else begin
                        w_state_nxt = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    w_load_en   = 1'b1;
                    w_load_data = mem_rdata;
                    w_state_nxt = RD_DONE;
                end
            end
            RD_DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Read request capture and response register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_idx   <= '0;
            r_rd_oor   <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (w_latch_req) begin
                r_rd_idx <= w_idx;
                r_rd_oor <= ~w_in_range;
            end
            if (w_load_en) begin
                r_readdata <= w_load_data;
            end
        end
    end

endmodule

// File: tb/tb_snake_px_responder.sv
// Scoreboard bench for snake_px_responder: directed pixel writes/reads against a simple
// memory responder; expected memory commands and read data are queued and checked by a monitor.
module tb_snake_px_responder;

    localparam int NX = 320;
    localparam int NY = 240;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] px_address = '0;
    logic        px_read = 1'b0;
    logic        px_write = 1'b0;
    logic [15:0] px_writedata = '0;
    logic [15:0] px_readdata;
    logic        px_waitrequest;
    logic [16:0] mem_address;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_writedata;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] px_dropped;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_wr[$];
    logic [16:0] exp_rd_addr[$];
    logic [15:0] exp_rd_data[$];
    logic [32:0] mon_e;
    logic [16:0] mon_a;
    logic [15:0] mon_d;

    logic        rd_hs = 1'b0;
    logic        resp_en = 1'b1;
    logic        stray_rv = 1'b0;
    logic [15:0] resp_data = '0;
    logic [15:0] stray_data = '0;
    int          wr_count = 0;
    logic [16:0] last_wr_addr = '0;

    always #5 clk = ~clk;

    snake_px_responder dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .px_address     (px_address),
        .px_read        (px_read),
        .px_write       (px_write),
        .px_writedata   (px_writedata),
        .px_readdata    (px_readdata),
        .px_waitrequest (px_waitrequest),
        .mem_address    (mem_address),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_writedata  (mem_writedata),
        .mem_ready      (mem_ready),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .px_dropped     (px_dropped)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: handshakes are sampled mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_write && mem_ready) begin
                wr_count++;
                last_wr_addr = mem_address;
                chk("mem_write_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    mon_e = exp_wr.pop_front();
                    chk("wr_addr", 32'(mem_address), 32'(mon_e[32:16]));
                    chk("wr_data", 32'(mem_writedata), 32'(mon_e[15:0]));
                end
            end
            if (mem_read && mem_ready) begin
                chk("rd_after_writes_drained", 32'(exp_wr.size()), 32'd0);
                chk("mem_read_expected", 32'(exp_rd_addr.size() != 0), 32'd1);
                if (exp_rd_addr.size() != 0) begin
                    mon_a = exp_rd_addr.pop_front();
                    chk("rd_addr", 32'(mem_address), 32'(mon_a));
                end
            end
            if (px_read && !px_write && !px_waitrequest) begin
                chk("rd_resp_expected", 32'(exp_rd_data.size() != 0), 32'd1);
                if (exp_rd_data.size() != 0) begin
                    mon_d = exp_rd_data.pop_front();
                    chk("px_readdata", 32'(px_readdata), 32'(mon_d));
                end
            end
        end
        rd_hs = reset_n && mem_read && mem_ready && resp_en;
    end

    // Memory responder: read data one cycle after the command handshake.
    always @(posedge clk) begin
        #1;
        mem_rvalid = rd_hs | stray_rv;
        mem_rdata  = stray_rv ? stray_data : resp_data;
    end

    task automatic do_write(input int x, input int y, input logic [15:0] d, input int idx,
                            output int stalls);
        px_address   = (32'(x) << 1) | (32'(y) << 10);
        px_writedata = d;
        px_write     = 1'b1;
        if (idx >= 0) exp_wr.push_back({17'(idx), d});
        stalls = 0;
        @(negedge clk);
        while (px_waitrequest && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 200) chk("write_timeout", 32'(stalls), 32'd0);
        @(posedge clk);
        #1;
        px_write = 1'b0;
    endtask

    task automatic do_read(input int x, input int y, input int idx, input logic [15:0] d,
                           output int lat);
        px_address = (32'(x) << 1) | (32'(y) << 10);
        px_read    = 1'b1;
        if (idx >= 0) exp_rd_addr.push_back(17'(idx));
        exp_rd_data.push_back(d);
        lat = 0;
        @(negedge clk);
        while (px_waitrequest && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        if (lat >= 200) chk("read_timeout", 32'(lat), 32'd0);
        @(posedge clk);
        #1;
        px_read = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        px_read  = 1'b0;
        px_write = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int st5;
        int lat;
        int tot_st;
        int n;

        // Reset values.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_waitrequest", 32'(px_waitrequest), 32'd1);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_writedata", 32'(mem_writedata), 32'd0);
        chk("rst_px_readdata", 32'(px_readdata), 32'd0);
        chk("rst_px_dropped", 32'(px_dropped), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // First write: (5,2) -> 645, visible on mem_write the cycle after accept.
        mem_ready    = 1'b1;
        px_address   = (32'd5 << 1) | (32'd2 << 10);
        px_writedata = 16'hFF00;
        px_write     = 1'b1;
        exp_wr.push_back({17'd645, 16'hFF00});
        @(negedge clk);
        chk("w1_no_stall", 32'(px_waitrequest), 32'd0);
        chk("w1_not_yet_on_mem", 32'(mem_write), 32'd0);
        @(posedge clk);
        #1;
        px_write = 1'b0;
        chk("w1_mem_write", 32'(mem_write), 32'd1);
        chk("w1_mem_address", 32'(mem_address), 32'd645);
        chk("w1_mem_writedata", 32'(mem_writedata), 32'hFF00);
        repeat (3) tick();

        // Backpressure: four fit, the fifth stalls until the memory accepts.
        mem_ready = 1'b0;
        do_write(10, 0, 16'h0A0A, 10, st); chk("bp_w1_stall", 32'(st), 32'd0);
        do_write(11, 0, 16'h0B0B, 11, st); chk("bp_w2_stall", 32'(st), 32'd0);
        do_write(12, 0, 16'h0C0C, 12, st); chk("bp_w3_stall", 32'(st), 32'd0);
        do_write(13, 0, 16'h0D0D, 13, st); chk("bp_w4_stall", 32'(st), 32'd0);
        fork
            do_write(14, 0, 16'h0E0E, 14, st5);
            begin
                repeat (4) @(negedge clk);
                chk("bp_w5_waitrequest", 32'(px_waitrequest), 32'd1);
                @(posedge clk);
                #1;
                mem_ready = 1'b1;
            end
        join
        chk("bp_w5_stall", 32'(st5), 32'd5);
        repeat (8) tick();
        chk("bp_drained", 32'(exp_wr.size()), 32'd0);

        // Read-after-write: read waits behind three queued writes.
        mem_ready = 1'b0;
        resp_data = 16'h00FF;
        do_write(1, 0, 16'h1111, 1, st);
        do_write(2, 0, 16'h2222, 2, st);
        do_write(0, 1, 16'h3333, 320, st);
        fork
            do_read(5, 2, 645, 16'h00FF, lat);
            begin
                repeat (3) tick();
                mem_ready = 1'b1;
            end
        join
        tick();

        // Read latency with an empty FIFO.
        resp_data = 16'h1234;
        do_read(1, 1, 321, 16'h1234, lat);
        chk("rd_latency", 32'(lat), 32'd4);
        tick();

        // Out-of-range writes and read.
        do_write(320, 0, 16'hDEAD, -1, st);
        do_write(0, 240, 16'hBEEF, -1, st);
        repeat (3) tick();
        chk("oor_dropped", 32'(px_dropped), 32'd2);
        chk("oor_no_mem_write", 32'(mem_write), 32'd0);
        do_read(320, 239, -1, 16'h0000, lat);
        chk("oor_rd_latency", 32'(lat), 32'd2);
        tick();

        // Full clear-screen sweep with inclusive bounds.
        do_reset();
        mem_ready = 1'b1;
        wr_count  = 0;
        tot_st    = 0;
        for (int y = 0; y <= NY; y++) begin
            for (int x = 0; x <= NX; x++) begin
                do_write(x, y, 16'(x ^ (y << 7)), (x < NX && y < NY) ? (y * NX + x) : -1, st);
                tot_st += st;
            end
        end
        repeat (4) tick();
        chk("sweep_write_count", 32'(wr_count), 32'd76800);
        chk("sweep_last_index", 32'(last_wr_addr), 32'd76799);
        chk("sweep_dropped", 32'(px_dropped), 32'd561);
        chk("sweep_stalls", 32'(tot_st), 32'd0);

        // Reset while waiting for read data, then a stray rvalid.
        do_reset();
        resp_en    = 1'b0;
        px_address = (32'd7 << 1) | (32'd3 << 10);
        px_read    = 1'b1;
        exp_rd_addr.push_back(17'd967);
        n = 0;
        @(negedge clk);
        while (!(mem_read && mem_ready) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("midrd_issue_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        tick();
        reset_n = 1'b0;
        px_read = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        stray_data = 16'hBEEF;
        stray_rv   = 1'b1;
        repeat (2) tick();
        stray_rv = 1'b0;
        repeat (2) tick();
        chk("midrd_readdata", 32'(px_readdata), 32'd0);
        chk("midrd_mem_read", 32'(mem_read), 32'd0);
        chk("midrd_fifo_empty", 32'(mem_write), 32'd0);
        chk("midrd_idle_no_stall", 32'(px_waitrequest), 32'd0);
        resp_en   = 1'b1;
        resp_data = 16'h5A5A;
        do_read(7, 3, 967, 16'h5A5A, lat);
        chk("midrd_next_rd_latency", 32'(lat), 32'd4);
        repeat (3) tick();

        chk("final_wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("final_rd_queue_empty", 32'(exp_rd_data.size()), 32'd0);
        chk("final_rd_addr_queue_empty", 32'(exp_rd_addr.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
